// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, stall and bubble insertion.
// A RUN/STALL FSM holds IF/ID for LOAD_USE_STALLS cycles while bubbles are injected into EX.
module idex_stage_reg #(
   parameter int REG_ADDR_W      = 4,
   parameter int DATA_W          = 16,
   parameter int LOAD_USE_STALLS = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  IFID_valid,
   input  logic [REG_ADDR_W-1:0] IFID_rs,
   input  logic [REG_ADDR_W-1:0] IFID_rt,
   input  logic [REG_ADDR_W-1:0] IFID_rd,
   input  logic                  IFID_uses_rt,
   input  logic [DATA_W-1:0]     rs_data,
   input  logic [DATA_W-1:0]     rt_data,
   input  logic [DATA_W-1:0]     imm_in,
   input  logic                  ALU_src_in,
   input  logic [3:0]            alu_op_in,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  reg_write_in,
   output logic                  stall,
   output logic                  IDEX_valid,
   output logic [REG_ADDR_W-1:0] IDEX_rs,
   output logic [REG_ADDR_W-1:0] IDEX_rt,
   output logic [REG_ADDR_W-1:0] IDEX_rd,
   output logic [DATA_W-1:0]     IDEX_rs_data,
   output logic [DATA_W-1:0]     IDEX_rt_data,
   output logic [DATA_W-1:0]     IDEX_imm,
   output logic                  ALU_src,
   output logic [3:0]            IDEX_alu_op,
   output logic                  IDEX_mem_read,
   output logic                  IDEX_mem_write,
   output logic                  IDEX_reg_write,
   output logic [15:0]           bubble_cnt
);

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALLS - 1);

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;
   logic [15:0] bubble_cnt_reg;
   logic        hazard;
   logic        load_bubble;

   // Register 0 is deliberately not excluded from the comparison.
   assign hazard = IDEX_valid & IDEX_mem_read & IFID_valid &
                   ((IDEX_rd == IFID_rs) | (IFID_uses_rt & (IDEX_rd == IFID_rt)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (flush) begin
         state_next = RUN;
         cnt_next   = '0;
      end else if (state_reg == STALL) begin
         cnt_next = cnt_reg - 3'd1;
         if (cnt_reg <= 3'd1) state_next = RUN;
      end else if (hazard) begin
         cnt_next = STALL_INIT;
         if (STALL_INIT != 3'd0) state_next = STALL;
      end
   end

   always_comb begin
      stall       = !flush & ((state_reg == STALL) | hazard);
      load_bubble = flush | stall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || load_bubble) begin
         IDEX_valid     <= 1'b0;
         IDEX_rs        <= '0;
         IDEX_rt        <= '0;
         IDEX_rd        <= '0;
         IDEX_rs_data   <= '0;
         IDEX_rt_data   <= '0;
         IDEX_imm       <= '0;
         ALU_src        <= 1'b0;
         IDEX_alu_op    <= '0;
         IDEX_mem_read  <= 1'b0;
         IDEX_mem_write <= 1'b0;
         IDEX_reg_write <= 1'b0;
      end else begin
         IDEX_valid     <= IFID_valid;
         IDEX_rs        <= IFID_rs;
         IDEX_rt        <= IFID_rt;
         IDEX_rd        <= IFID_rd;
         IDEX_rs_data   <= rs_data;
         IDEX_rt_data   <= rt_data;
         IDEX_imm       <= imm_in;
         ALU_src        <= ALU_src_in;
         IDEX_alu_op    <= alu_op_in;
         IDEX_mem_read  <= mem_read_in;
         IDEX_mem_write <= mem_write_in;
         IDEX_reg_write <= reg_write_in;
      end
   end

   // Only hazard/STALL bubbles are counted; flush squashes are not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_reg <= '0;
      end else if (stall && (bubble_cnt_reg != 16'hFFFF)) begin
         bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
      end
   end

   assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg: default instance (1 stall) and a 3-stall instance
// share the same IF/ID stimulus.
module tb_idex_stage_reg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        IFID_valid = 1'b0;
   logic [3:0]  IFID_rs = '0, IFID_rt = '0, IFID_rd = '0;
   logic        IFID_uses_rt = 1'b0;
   logic [15:0] rs_data = '0, rt_data = '0, imm_in = '0;
   logic        ALU_src_in = 1'b0;
   logic [3:0]  alu_op_in = '0;
   logic        mem_read_in = 1'b0, mem_write_in = 1'b0, reg_write_in = 1'b0;

   logic        stall, IDEX_valid, ALU_src, IDEX_mem_read, IDEX_mem_write, IDEX_reg_write;
   logic [3:0]  IDEX_rs, IDEX_rt, IDEX_rd, IDEX_alu_op;
   logic [15:0] IDEX_rs_data, IDEX_rt_data, IDEX_imm, bubble_cnt;

   logic        stall3, IDEX_valid3, ALU_src3, IDEX_mem_read3, IDEX_mem_write3, IDEX_reg_write3;
   logic [3:0]  IDEX_rs3, IDEX_rt3, IDEX_rd3, IDEX_alu_op3;
   logic [15:0] IDEX_rs_data3, IDEX_rt_data3, IDEX_imm3, bubble_cnt3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   idex_stage_reg dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .IFID_valid(IFID_valid),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_rd(IFID_rd), .IFID_uses_rt(IFID_uses_rt),
      .rs_data(rs_data), .rt_data(rt_data), .imm_in(imm_in), .ALU_src_in(ALU_src_in),
      .alu_op_in(alu_op_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .reg_write_in(reg_write_in), .stall(stall), .IDEX_valid(IDEX_valid),
      .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt), .IDEX_rd(IDEX_rd), .IDEX_rs_data(IDEX_rs_data),
      .IDEX_rt_data(IDEX_rt_data), .IDEX_imm(IDEX_imm), .ALU_src(ALU_src),
      .IDEX_alu_op(IDEX_alu_op), .IDEX_mem_read(IDEX_mem_read),
      .IDEX_mem_write(IDEX_mem_write), .IDEX_reg_write(IDEX_reg_write),
      .bubble_cnt(bubble_cnt)
   );

   idex_stage_reg #(.LOAD_USE_STALLS(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .IFID_valid(IFID_valid),
      .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_rd(IFID_rd), .IFID_uses_rt(IFID_uses_rt),
      .rs_data(rs_data), .rt_data(rt_data), .imm_in(imm_in), .ALU_src_in(ALU_src_in),
      .alu_op_in(alu_op_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .reg_write_in(reg_write_in), .stall(stall3), .IDEX_valid(IDEX_valid3),
      .IDEX_rs(IDEX_rs3), .IDEX_rt(IDEX_rt3), .IDEX_rd(IDEX_rd3), .IDEX_rs_data(IDEX_rs_data3),
      .IDEX_rt_data(IDEX_rt_data3), .IDEX_imm(IDEX_imm3), .ALU_src(ALU_src3),
      .IDEX_alu_op(IDEX_alu_op3), .IDEX_mem_read(IDEX_mem_read3),
      .IDEX_mem_write(IDEX_mem_write3), .IDEX_reg_write(IDEX_reg_write3),
      .bubble_cnt(bubble_cnt3)
   );

   task automatic set_ifid(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                           input logic [3:0] rd, input logic urt, input logic mr, input logic rw);
      IFID_valid = v; IFID_rs = rs; IFID_rt = rt; IFID_rd = rd;
      IFID_uses_rt = urt; mem_read_in = mr; reg_write_in = rw;
   endtask

   task automatic apply_reset;
      rst_n = 1'b0; flush = 1'b0;
      set_ifid(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      rs_data = '0; rt_data = '0; imm_in = '0; ALU_src_in = 1'b0; alu_op_in = '0; mem_write_in = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Puts "lw r7 <- [r1]" into ID/EX.
   task automatic load_lw7;
      @(negedge clk);
      set_ifid(1'b1, 4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      apply_reset;
      #1;
      vectors++; if (IDEX_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", IDEX_valid); end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", stall); end
      vectors++; if (bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got=%h exp=0000", bubble_cnt); end
      @(negedge clk);
      set_ifid(1'b1, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 1'b1);
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      vectors++; if (IDEX_valid !== 1'b0 || IDEX_rd !== 4'd0) begin miscompares++;
         $display("FAIL async_reset got valid=%b rd=%0d exp valid=0 rd=0", IDEX_valid, IDEX_rd); end
      @(negedge clk); rst_n = 1'b1;
      load_lw7;
      @(negedge clk);
      set_ifid(1'b1, 4'd7, 4'd0, 4'd8, 1'b0, 1'b0, 1'b1);
      #2;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL prereset_stall got=%b exp=1", stall); end
      rst_n = 1'b0; #1;
      vectors++; if (stall !== 1'b0 || IDEX_mem_read !== 1'b0) begin miscompares++;
         $display("FAIL midstall_reset got stall=%b mr=%b exp 0 0", stall, IDEX_mem_read); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_passthrough;
      apply_reset;
      @(negedge clk);
      set_ifid(1'b1, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 1'b1);
      alu_op_in = 4'd2; rs_data = 16'h1234; rt_data = 16'hABCD; imm_in = 16'hFFF0; ALU_src_in = 1'b1;
      #2;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL pass_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      vectors++; if (IDEX_rs !== 4'd3 || IDEX_rt !== 4'd4 || IDEX_rd !== 4'd5) begin miscompares++;
         $display("FAIL pass_regs got rs=%0d rt=%0d rd=%0d exp 3 4 5", IDEX_rs, IDEX_rt, IDEX_rd); end
      vectors++; if (IDEX_alu_op !== 4'd2 || ALU_src !== 1'b1 || IDEX_valid !== 1'b1 || IDEX_reg_write !== 1'b1
                     || IDEX_mem_read !== 1'b0) begin miscompares++;
         $display("FAIL pass_ctrl got op=%0d src=%b v=%b rw=%b mr=%b exp 2 1 1 1 0",
                  IDEX_alu_op, ALU_src, IDEX_valid, IDEX_reg_write, IDEX_mem_read); end
      vectors++; if (IDEX_rs_data !== 16'h1234 || IDEX_rt_data !== 16'hABCD || IDEX_imm !== 16'hFFF0) begin miscompares++;
         $display("FAIL pass_data got %h %h %h exp 1234 abcd fff0", IDEX_rs_data, IDEX_rt_data, IDEX_imm); end
      @(negedge clk);
      set_ifid(1'b0, 4'd9, 4'd10, 4'd11, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      vectors++; if (IDEX_valid !== 1'b0 || IDEX_rs !== 4'd9) begin miscompares++;
         $display("FAIL pass_invalid got v=%b rs=%0d exp 0 9", IDEX_valid, IDEX_rs); end
   endtask

   task automatic test_load_use;
      apply_reset;
      load_lw7;
      @(negedge clk);
      set_ifid(1'b1, 4'd7, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1);
      #2;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_rs_stall got=%b exp=1", stall); end
      @(posedge clk); #1;
      vectors++; if (IDEX_valid !== 1'b0 || IDEX_rd !== 4'd0 || bubble_cnt !== 16'd1) begin miscompares++;
         $display("FAIL lu_bubble got v=%b rd=%0d cnt=%0d exp 0 0 1", IDEX_valid, IDEX_rd, bubble_cnt); end
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_release got=%b exp=0", stall); end
      @(posedge clk); #1;
      vectors++; if (IDEX_rs !== 4'd7 || IDEX_rd !== 4'd8 || IDEX_valid !== 1'b1 || bubble_cnt !== 16'd1) begin miscompares++;
         $display("FAIL lu_capture got rs=%0d rd=%0d v=%b cnt=%0d exp 7 8 1 1", IDEX_rs, IDEX_rd, IDEX_valid, bubble_cnt); end
      load_lw7;
      @(negedge clk);
      set_ifid(1'b1, 4'd1, 4'd7, 4'd9, 1'b0, 1'b0, 1'b1);
      #2;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_rt_unused got=%b exp=0", stall); end
      IFID_uses_rt = 1'b1; #1;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_rt_used got=%b exp=1", stall); end
      IFID_uses_rt = 1'b0; IFID_valid = 1'b0; IFID_rs = 4'd7; #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_ifid_invalid got=%b exp=0", stall); end
      IFID_valid = 1'b1; IFID_rs = 4'd1;
      @(posedge clk); #1;
      vectors++; if (IDEX_rt !== 4'd7 || IDEX_valid !== 1'b1 || bubble_cnt !== 16'd1) begin miscompares++;
         $display("FAIL lu_rt_capture got rt=%0d v=%b cnt=%0d exp 7 1 1", IDEX_rt, IDEX_valid, bubble_cnt); end
      @(negedge clk);
      set_ifid(1'b1, 4'd2, 4'd3, 4'd0, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      set_ifid(1'b1, 4'd0, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1);
      #2;
      vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_reg0 got=%b exp=1", stall); end
   endtask

   task automatic test_multi_stall;
      int n;
      apply_reset;
      load_lw7;
      @(negedge clk);
      set_ifid(1'b1, 4'd7, 4'd0, 4'd8, 1'b0, 1'b0, 1'b1);
      #1;
      n = 0;
      for (int i = 0; i < 8 && stall3 === 1'b1; i++) begin
         n++;
         @(posedge clk); #1;
         vectors++; if (IDEX_valid3 !== 1'b0) begin miscompares++; $display("FAIL ms_bubble%0d got v=%b exp=0", i, IDEX_valid3); end
      end
      vectors++; if (n != 3) begin miscompares++; $display("FAIL ms_stall_cycles got=%0d exp=3", n); end
      vectors++; if (bubble_cnt3 !== 16'd3) begin miscompares++; $display("FAIL ms_cnt got=%0d exp=3", bubble_cnt3); end
      @(posedge clk); #1;
      vectors++; if (IDEX_rs3 !== 4'd7 || IDEX_valid3 !== 1'b1) begin miscompares++;
         $display("FAIL ms_capture got rs=%0d v=%b exp 7 1", IDEX_rs3, IDEX_valid3); end
   endtask

   task automatic test_flush;
      apply_reset;
      load_lw7;
      @(negedge clk);
      set_ifid(1'b1, 4'd7, 4'd0, 4'd8, 1'b0, 1'b0, 1'b1);
      flush = 1'b1; #2;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL fl_hazard_stall got=%b exp=0", stall); end
      @(posedge clk); #1;
      vectors++; if (IDEX_valid !== 1'b0 || IDEX_rs !== 4'd0 || bubble_cnt !== 16'd0) begin miscompares++;
         $display("FAIL fl_hazard_bubble got v=%b rs=%0d cnt=%0d exp 0 0 0", IDEX_valid, IDEX_rs, bubble_cnt); end
      flush = 1'b0;
      @(posedge clk); #1;
      vectors++; if (IDEX_rs !== 4'd7 || IDEX_valid !== 1'b1) begin miscompares++;
         $display("FAIL fl_recover got rs=%0d v=%b exp 7 1", IDEX_rs, IDEX_valid); end
      apply_reset;
      load_lw7;
      @(negedge clk);
      set_ifid(1'b1, 4'd7, 4'd0, 4'd8, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      vectors++; if (stall3 !== 1'b1) begin miscompares++; $display("FAIL fl_in_stall_state got=%b exp=1", stall3); end
      @(negedge clk);
      flush = 1'b1; #1;
      vectors++; if (stall3 !== 1'b0) begin miscompares++; $display("FAIL fl_stall_drop got=%b exp=0", stall3); end
      @(posedge clk); #1;
      vectors++; if (bubble_cnt3 !== 16'd1 || IDEX_valid3 !== 1'b0) begin miscompares++;
         $display("FAIL fl_stall_cnt got cnt=%0d v=%b exp 1 0", bubble_cnt3, IDEX_valid3); end
      flush = 1'b0; #1;
      vectors++; if (stall3 !== 1'b0) begin miscompares++; $display("FAIL fl_back_to_run got=%b exp=0", stall3); end
      @(posedge clk); #1;
      vectors++; if (IDEX_rs3 !== 4'd7 || IDEX_valid3 !== 1'b1) begin miscompares++;
         $display("FAIL fl_stall_capture got rs=%0d v=%b exp 7 1", IDEX_rs3, IDEX_valid3); end
   endtask

   task automatic hazard_once;
      load_lw7;
      @(negedge clk);
      set_ifid(1'b1, 4'd7, 4'd0, 4'd8, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic test_saturation;
      apply_reset;
      @(negedge clk);
      force dut1.bubble_cnt_reg = 16'hFFFE;
      #1;
      release dut1.bubble_cnt_reg;
      hazard_once;
      vectors++; if (bubble_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_first got=%h exp=ffff", bubble_cnt); end
      hazard_once;
      vectors++; if (bubble_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got=%h exp=ffff", bubble_cnt); end
   endtask

   initial begin
      test_reset;
      test_passthrough;
      test_load_use;
      test_multi_stall;
      test_flush;
      test_saturation;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
